// File: rtl/spi_bufr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_bufr_pkg
// Description : Shared defaults and helpers for the SPI buffer FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_bufr_pkg;

    localparam int C_BUFR_DWIDTH    = 8;
    localparam int C_BUFR_DEPTH     = 16;
    localparam int C_BUFR_AE_THRESH = 2;

    // Level counter must represent 0..depth inclusive, hence one extra bit.
    function automatic int f_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bufr_mem.sv
`default_nettype none
// ============================================================================
// Module      : spi_bufr_mem
// Description : P_DEPTH x P_DWIDTH simple dual-port storage, synchronous write,
//               asynchronous read. Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bufr_mem
    import spi_bufr_pkg::*;
#(
    parameter int P_DWIDTH = C_BUFR_DWIDTH,
    parameter int P_DEPTH  = C_BUFR_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(P_DEPTH)-1:0] waddr,
    input  logic [P_DWIDTH-1:0]        wdata,
    input  logic [$clog2(P_DEPTH)-1:0] raddr,
    output logic [P_DWIDTH-1:0]        rdata
);

    logic [P_DWIDTH-1:0] r_mem [P_DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/spi_bufr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_bufr_fifo
// Description : Synchronous FIFO with level, almost-empty and sticky error
//               flags. Define SPI_BUFR_FWFT_EN for first-word-fall-through
//               mode; otherwise rdata is a registered 1-cycle-latency read.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bufr_fifo
    import spi_bufr_pkg::*;
#(
    parameter int P_DWIDTH    = C_BUFR_DWIDTH,
    parameter int P_DEPTH     = C_BUFR_DEPTH,
    parameter int P_AE_THRESH = C_BUFR_AE_THRESH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wen,
    input  logic [P_DWIDTH-1:0]                 wdata,
    output logic                                wfull,
    input  logic                                ren,
    output logic [P_DWIDTH-1:0]                 rdata,
    output logic                                rempty,
    output logic                                ralmost_empty,
    output logic [f_level_width(P_DEPTH)-1:0]   rlevel,
    output logic                                err_ovf,
    output logic                                err_udf,
    input  logic                                clr_err
);

    localparam int c_addr_w = $clog2(P_DEPTH);
    localparam int c_lvl_w  = f_level_width(P_DEPTH);

    localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);
    localparam logic [c_lvl_w-1:0]  c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0]  c_lvl_full = c_lvl_w'(P_DEPTH);
    localparam logic [c_lvl_w-1:0]  c_lvl_ae   = c_lvl_w'(P_AE_THRESH);

    logic [c_addr_w-1:0] r_wptr;
    logic [c_addr_w-1:0] r_rptr;
    logic [c_lvl_w-1:0]  r_level;
    logic                r_err_ovf;
    logic                r_err_udf;
    logic [P_DWIDTH-1:0] r_rdata;

    logic [P_DWIDTH-1:0] w_mem_rdata;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_mem_we;
    logic                w_rptr_adv;

    assign w_full   = (r_level == c_lvl_full);
    assign w_wr_acc = wen & ~w_full;

`ifdef SPI_BUFR_FWFT_EN
    // The prefetch register holds the head word; rlevel counts it, so the
    // array itself holds rlevel - r_pf_valid words.
    logic               r_pf_valid;
    logic [c_lvl_w-1:0] w_mem_cnt;
    logic               w_mem_nonempty;
    logic               w_pf_load;
    logic               w_bypass;

    assign w_empty        = ~r_pf_valid;
    assign w_rd_acc       = ren & r_pf_valid;
    assign w_mem_cnt      = r_level - {{(c_lvl_w-1){1'b0}}, r_pf_valid};
    assign w_mem_nonempty = (w_mem_cnt != '0);
    // Prefetch slot is free now or is being vacated by this read.
    assign w_pf_load      = ~r_pf_valid | w_rd_acc;
    assign w_rptr_adv     = w_pf_load & w_mem_nonempty;
    // With nothing waiting in the array, a write lands straight in the
    // prefetch register so rempty drops one cycle after the write.
    assign w_bypass       = w_pf_load & ~w_mem_nonempty & w_wr_acc;
    assign w_mem_we       = w_wr_acc & ~w_bypass;

    // Prefetch register refill from the array head or from the bypassed write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pf_valid <= 1'b0;
            r_rdata    <= '0;
        end else if (w_pf_load) begin
            if (w_rptr_adv) begin
                r_rdata    <= w_mem_rdata;
                r_pf_valid <= 1'b1;
            end else if (w_bypass) begin
                r_rdata    <= wdata;
                r_pf_valid <= 1'b1;
            end else begin
                r_pf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_empty    = (r_level == '0);
    assign w_rd_acc   = ren & ~w_empty;
    assign w_rptr_adv = w_rd_acc;
    assign w_mem_we   = w_wr_acc;

    // Registered read data; holds its value while no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_acc) begin
            r_rdata <= w_mem_rdata;
        end
    end
`endif

    spi_bufr_mem #(
        .P_DWIDTH (P_DWIDTH),
        .P_DEPTH  (P_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wptr),
        .wdata (wdata),
        .raddr (r_rptr),
        .rdata (w_mem_rdata)
    );

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_mem_we) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rptr_adv) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Level tracks accepted accesses; read+write together leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_level <= r_level + c_lvl_one;
        end else if (!w_wr_acc && w_rd_acc) begin
            r_level <= r_level - c_lvl_one;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= (wen & w_full)  | (r_err_ovf & ~clr_err);
            r_err_udf <= (ren & w_empty) | (r_err_udf & ~clr_err);
        end
    end

    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign ralmost_empty = (r_level <= c_lvl_ae);
    assign rlevel        = r_level;
    assign rdata         = r_rdata;
    assign err_ovf       = r_err_ovf;
    assign err_udf       = r_err_udf;

endmodule
`default_nettype wire

// File: tb/tb_spi_bufr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bufr_fifo
// Description : Directed self-checking bench for spi_bufr_fifo (default
//               parameters). Follows SPI_BUFR_FWFT_EN for rdata expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bufr_fifo;

    localparam int c_depth = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wfull;
    logic       ren = 1'b0;
    logic [7:0] rdata;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;
    logic       err_ovf;
    logic       err_udf;
    logic       clr_err = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    spi_bufr_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .wen           (wen),
        .wdata         (wdata),
        .wfull         (wfull),
        .ren           (ren),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .err_ovf       (err_ovf),
        .err_udf       (err_udf),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = m_q.size();
        check_val({tag, ".rlevel"}, 32'(rlevel), 32'(sz));
        check_val({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
        check_val({tag, ".wfull"}, 32'(wfull), 32'(sz == c_depth));
        check_val({tag, ".almost_empty"}, 32'(ralmost_empty), 32'(sz <= 2));
        check_val({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
        check_val({tag, ".err_ovf"}, 32'(err_ovf), 32'(m_ovf));
        check_val({tag, ".err_udf"}, 32'(err_udf), 32'(m_udf));
    endtask

    // Apply one cycle of stimulus, advance the model, then compare.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [7:0] d, input logic c);
        logic wr_ok;
        logic rd_ok;
        logic [7:0] popped;
        wen = w; ren = r; wdata = d; clr_err = c;
        wr_ok = w && (m_q.size() < c_depth);
        rd_ok = r && (m_q.size() > 0);
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
        if (rd_ok) begin
            popped = m_q.pop_front();
`ifndef SPI_BUFR_FWFT_EN
            m_rdata = popped;
`endif
        end
        if (wr_ok) m_q.push_back(d);
`ifdef SPI_BUFR_FWFT_EN
        if (m_q.size() > 0) m_rdata = m_q[0];
`endif
        m_ovf = (w && !wr_ok) || (m_ovf && !c);
        m_udf = (r && !rd_ok) || (m_udf && !c);
        check_state(tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b0;

        // Single write then read of 0xA5
        step("wr_a5", 1'b1, 1'b0, 8'hA5, 1'b0);
        check_val("wr_a5_rempty_low", 32'(rempty), 32'd0);
        step("rd_a5", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("rd_a5_rdata", 32'(rdata), 32'hA5);

        // Fill to full, then overflow with 0xFF
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        check_val("full_level", 32'(rlevel), 32'd16);
        check_val("full_flag", 32'(wfull), 32'd1);
        step("ovf", 1'b1, 1'b0, 8'hFF, 1'b0);
        check_val("ovf_flag", 32'(err_ovf), 32'd1);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("drain_last", 32'(rdata), 32'h0F);

        // Underflow, clear, and set-wins-over-clear
        step("udf", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("udf_rdata_held", 32'(rdata), 32'h0F);
        step("clr", 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("clr_ovf", 32'(err_ovf), 32'd0);
        step("udf_vs_clr", 1'b0, 1'b1, 8'h00, 1'b1);
        check_val("set_wins", 32'(err_udf), 32'd1);
        step("clr2", 1'b0, 1'b0, 8'h00, 1'b1);

        // Read+write while empty: write accepted, underflow flagged
        step("rw_empty", 1'b1, 1'b1, 8'h77, 1'b0);
        step("clr3", 1'b0, 1'b0, 8'h00, 1'b1);

        // Stream at level 8 for 40 cycles
        for (int i = 0; i < 7; i++) step("to8", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) step("stream", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        check_val("stream_level", 32'(rlevel), 32'd8);

        // Read+write while full: pop succeeds, write dropped
        for (int i = 0; i < 8; i++) step("to16", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        step("rw_full", 1'b1, 1'b1, 8'hEE, 1'b0);
        check_val("rw_full_level", 32'(rlevel), 32'd15);
        step("clr4", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step("to5", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("pre_rst_level", 32'(rlevel), 32'd5);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        m_q.delete();
        m_rdata = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Post-reset operation, almost-empty boundary 3 -> 2
        step("post_w0", 1'b1, 1'b0, 8'h3C, 1'b0);
        step("post_w1", 1'b1, 1'b0, 8'h3D, 1'b0);
        step("post_w2", 1'b1, 1'b0, 8'h3E, 1'b0);
        check_val("ae_at3", 32'(ralmost_empty), 32'd0);
        step("post_r0", 1'b0, 1'b1, 8'h00, 1'b0);
        check_val("ae_at2", 32'(ralmost_empty), 32'd1);
        step("post_r1", 1'b0, 1'b1, 8'h00, 1'b0);
        step("post_r2", 1'b0, 1'b1, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_bufr_fifo.md
SPI_BUFR_FIFO -- requirements
Module: spi_bufr_fifo

Interface
REQ-001 Parameter P_DWIDTH, default 8, SHALL set the data width of wdata/rdata in bits (legal range 1..32).
REQ-002 Parameter P_DEPTH, default 16, SHALL set the entry count (power of two, 2..256).
REQ-003 Parameter P_AE_THRESH, default 2, SHALL set the almost-empty threshold (0..P_DEPTH-1).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wen  input  1  write request.
REQ-007 wdata  input  P_DWIDTH  write data.
REQ-008 wfull  output  1  buffer full.
REQ-009 ren  input  1  read request.
REQ-010 rdata  output  P_DWIDTH  read data.
REQ-011 rempty  output  1  buffer empty, meaning no readable word.
REQ-012 ralmost_empty  output  1  level <= P_AE_THRESH.
REQ-013 rlevel  output  $clog2(P_DEPTH)+1  count of stored words.
REQ-014 err_ovf  output  1  sticky overflow.
REQ-015 err_udf  output  1  sticky underflow.
REQ-016 clr_err  input  1  one-cycle pulse that clears both sticky flags.

Function
REQ-017 A write SHALL be accepted when wen=1 and wfull=0: store wdata at wptr, and wptr advances modulo P_DEPTH.
REQ-018 wen=1 with wfull=1 SHALL drop the data, leave pointers and level unchanged, and set err_ovf on the next edge.
REQ-019 A read SHALL be accepted when ren=1 and rempty=0, and rptr advances modulo P_DEPTH.
REQ-020 ren=1 with rempty=1 SHALL leave rdata, pointers and level unchanged, and set err_udf.
REQ-021 Simultaneous accepted read and write SHALL keep rlevel constant.
REQ-022 When full, a simultaneous ren and wen SHALL pop the read and drop the write with err_ovf, because wfull gates the write.
REQ-023 When empty, a simultaneous ren and wen SHALL accept the write and flag err_udf.
REQ-024 rlevel SHALL be registered, with wfull = (rlevel==P_DEPTH) and rempty derived per REQ-030/REQ-031.
REQ-025 Flags SHALL update on the same edge as the access that changes them.
REQ-026 ralmost_empty SHALL be combinational from rlevel and SHALL be 1 when rlevel==0.
REQ-027 Pointer wrap from P_DEPTH-1 to 0 SHALL occur with no bubble cycle.
REQ-028 If clr_err and a new error occur in the same cycle, set SHALL win.
REQ-029 rdata SHALL hold its last value while no read is accepted.

Configuration
REQ-030 With SPI_BUFR_FWFT_EN defined, the block SHALL work in first-word-fall-through mode:
- a prefetch output register SHALL present the head word on rdata while rempty=0;
- an accepted ren SHALL advance rdata to the next word on the following edge;
- write-to-rempty-deassert latency SHALL be 1 cycle;
- rlevel SHALL include the prefetched word.
REQ-031 Without SPI_BUFR_FWFT_EN, the block SHALL work in standard mode:
- rempty = (rlevel==0);
- rdata SHALL be registered and SHALL show the popped word on the edge after an accepted ren (1-cycle read latency);
- write-to-rempty-deassert latency SHALL be 1 cycle.

Reset
REQ-032 While rst=1, the block SHALL hold wptr=0, rptr=0, rlevel=0, rempty=1, wfull=0, ralmost_empty=1, rdata=0, err_ovf=0, err_udf=0, and clear the prefetch valid bit.
REQ-033 Storage array contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored words immediately, with no clock required.
REQ-035 Accesses SHALL be ignored on the first edge after rst deasserts only if rst is still high at that edge.

Structure
REQ-036 Package spi_bufr_pkg SHALL hold:
- default constants C_BUFR_DWIDTH=8, C_BUFR_DEPTH=16, C_BUFR_AE_THRESH=2;
- a function for the rlevel width.
REQ-037 Sub-module spi_bufr_mem SHALL implement the storage as a P_DEPTH x P_DWIDTH simple dual-port array with synchronous write and asynchronous read.
REQ-038 Pointer, level, flag and prefetch logic SHALL reside in spi_bufr_fifo.

Verification (defaults unless stated)
REQ-039 Standard mode: write 0xA5 then ren -> rempty falls 1 cycle after the write; rdata=0xA5 one cycle after ren; rlevel returns to 0.
REQ-040 Fill with 16 writes 0x00..0x0F, then a 17th write 0xFF -> wfull=1 at rlevel=16, 0xFF dropped, err_ovf=1; 16 reads return 0x00..0x0F in order.
REQ-041 ren on an empty buffer -> err_udf=1 and rdata unchanged; clr_err pulse -> both flags return to 0.
REQ-042 Simultaneous read and write at rlevel=8 for 40 cycles -> rlevel stays 8, pointers wrap twice, data order is preserved.
REQ-043 FWFT build: write 0x3C -> rdata=0x3C with rempty=0 one cycle later and no ren needed; rlevel goes 3->2 with ralmost_empty rising at 2.
REQ-044 Assert rst at rlevel=5 between clock edges -> rempty=1, rlevel=0 and rdata=0 immediately.
